// File: rtl/panel_reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : panel_reg_loader
// Purpose  : Front-panel writer for the register file. A 32-bit word is keyed
//            one hex nibble at a time (key_next_n), then committed to the
//            register chosen on sw_addr (key_commit_n) through a req/ack port.
// Options  : LOADER_ECHO_SEG_EN - registered 7-seg echo of sw_nibble on
//            seg_nibble. When undefined, seg_nibble is held blank.
// Revision : 1.0 - initial release
// ============================================================================
module panel_reg_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_next_n,
  input  logic        key_commit_n,
  input  logic [3:0]  sw_nibble,
  input  logic [4:0]  sw_addr,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic        busy,
  output logic [2:0]  nibble_idx,
  output logic [31:0] entry_word,
  output logic        err,
  output logic [6:0]  seg_nibble
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_WRITE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  // Bit 0 = next key, bit 1 = commit key
  logic [1:0] key_raw_n;
  logic [1:0] key_press;

  assign key_raw_n = {key_commit_n, key_next_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;   // 1 = accepted as pressed
    logic            pulse_q, pulse_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_pressed;

    // Synchronize the raw key, then flip the stable state only after the
    // level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles
    always_comb begin
      sync1_d       = key_raw_n[k];
      sync2_d       = sync1_q;
      level_pressed = ~sync2_q;
      stable_d      = stable_q;
      pulse_d       = 1'b0;
      cnt_d         = '0;
      if (level_pressed != stable_q) begin
        if (cnt_q == DB_LAST) begin
          stable_d = level_pressed;
          pulse_d  = level_pressed;   // pulse only on the press edge
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    // Key synchronizer and debouncer registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        stable_q <= 1'b0;
        pulse_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        stable_q <= stable_d;
        pulse_q  <= pulse_d;
        cnt_q    <= cnt_d;
      end
    end

    assign key_press[k] = pulse_q;
  end

  state_t          state_q, state_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] tmo_q, tmo_d;

  // Entry/commit state machine: next-state and register updates
  always_comb begin
    state_d   = state_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    idx_d     = idx_q;
    word_d    = word_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_ENTRY: begin
        // Commit has priority over a simultaneous next press
        if (key_press[1]) begin
          if (sw_addr == 5'd0) begin
            err_d = 1'b1;            // register 0 is hardwired, refuse
          end else begin
            err_d     = 1'b0;
            wr_addr_d = sw_addr;
            wr_data_d = word_q;
            wr_en_d   = 1'b1;
            state_d   = ST_WRITE;
          end
        end else if (key_press[0]) begin
          word_d[{idx_q, 2'b00} +: 4] = sw_nibble;
          idx_d = idx_q + 3'd1;
          err_d = 1'b0;
        end
      end
      ST_WRITE: begin
        // Ack seen here is ignored; timing starts in WAIT_ACK
        tmo_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (wr_ack) begin
          wr_en_d = 1'b0;
          word_d  = '0;
          idx_d   = '0;
          state_d = ST_ENTRY;
        end else if (tmo_q == TO_LAST) begin
          wr_en_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ENTRY;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      default: begin
        wr_en_d = 1'b0;
        state_d = ST_ENTRY;
      end
    endcase
    busy_d = (state_d != ST_ENTRY);
  end

  // State machine and write-port registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ENTRY;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      idx_q     <= '0;
      word_q    <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign nibble_idx = idx_q;
  assign entry_word = word_q;
  assign err        = err_q;

`ifdef LOADER_ECHO_SEG_EN
  logic [6:0] seg_q, seg_d;

  // Active-low hex decode of the switch digit, segment order gfedcba
  always_comb begin
    seg_d = 7'b1111111;
    case (sw_nibble)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0011000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
      default: seg_d = 7'b1111111;
    endcase
  end

  // Segment echo register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_q <= 7'b1111111;
    else       seg_q <= seg_d;
  end

  assign seg_nibble = seg_q;
`else
  assign seg_nibble = 7'b1111111;
`endif

endmodule
`default_nettype wire

// File: tb/tb_panel_reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_panel_reg_loader
// Purpose  : Self-checking bench for panel_reg_loader. Register-file writes
//            are scoreboarded through a queue; entry state is compared with a
//            nibble-array model after every key operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_panel_reg_loader;

  localparam int DB = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_next_n = 1'b1;
  logic        key_commit_n = 1'b1;
  logic [3:0]  sw_nibble = 4'h0;
  logic [4:0]  sw_addr = 5'd0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack = 1'b0;
  logic        busy;
  logic [2:0]  nibble_idx;
  logic [31:0] entry_word;
  logic        err;
  logic [6:0]  seg_nibble;

  panel_reg_loader #(.DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .key_next_n(key_next_n), .key_commit_n(key_commit_n),
    .sw_nibble(sw_nibble), .sw_addr(sw_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .nibble_idx(nibble_idx),
    .entry_word(entry_word), .err(err), .seg_nibble(seg_nibble)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          len;
  } wr_t;

  wr_t exp_q[$];
  int  ack_delay = -1;   // cycle of the write (0 = WRITE cycle) to ack in, -1 never

  // Reference model: eight digit slots, a fill pointer and the error flag
  logic [3:0] m_nib [8];
  int         m_idx;
  logic       m_err;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic logic [31:0] m_word();
    logic [31:0] w;
    for (int i = 0; i < 8; i++) w[4*i +: 4] = m_nib[i];
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    m_idx = 0;
    m_err = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_nibble_idx"}, 32'(nibble_idx), 32'(m_idx));
    check({tag, "_entry_word"}, entry_word, m_word());
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick(1);
      n++;
    end
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 40) begin
      tick(1);
      n++;
    end
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_clear();
    tick(1);
  endtask

  task automatic press_next(input logic [3:0] nib);
    sw_nibble  = nib;
    key_next_n = 1'b0;
    tick(DB + 6);
    key_next_n = 1'b1;
    tick(DB + 6);
    m_nib[m_idx] = nib;
    m_idx = (m_idx + 1) % 8;
    m_err = 1'b0;
  endtask

  // Queue the expected write (if any) and return whether it will be acked
  function automatic bit model_commit_start(input logic [4:0] addr, input int delay);
    wr_t w;
    bit  ok;
    ok = (delay >= 1 && delay <= TO);
    if (addr != 5'd0) begin
      w.addr = addr;
      w.data = m_word();
      w.len  = ok ? delay + 1 : TO + 1;
      exp_q.push_back(w);
    end
    return ok;
  endfunction

  task automatic model_commit_end(input logic [4:0] addr, input bit ok);
    if (addr == 5'd0)  m_err = 1'b1;
    else if (ok)       begin model_clear(); end
    else               m_err = 1'b1;
  endtask

  task automatic press_commit(input logic [4:0] addr, input int delay);
    bit ok;
    ok = model_commit_start(addr, delay);
    sw_addr      = addr;
    ack_delay    = delay;
    key_commit_n = 1'b0;
    tick(DB + 6);
    key_commit_n = 1'b1;
    wait_idle();
    tick(DB + 6);
    model_commit_end(addr, ok);
  endtask

  // Monitor / register-file responder: pops the scoreboard on each write
  int  run = 0;
  bit  have = 1'b0;
  wr_t cur;
  always @(negedge clk) begin
    wr_ack = 1'b0;
    if (reset) begin
      run  = 0;
      have = 1'b0;
    end else if (wr_en) begin
      if (run == 0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          have = 1'b0;
          $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", wr_addr, wr_data);
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
        end
      end
      run++;
      if (have) begin
        check("wr_addr", 32'(wr_addr), 32'(cur.addr));
        check("wr_data", wr_data, cur.data);
      end
      if (ack_delay >= 0 && run == ack_delay + 1) wr_ack = 1'b1;
    end else if (run != 0) begin
      if (have) check("wr_len", 32'(run), 32'(cur.len));
      run  = 0;
      have = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] n;
    bit         ok;
    model_clear();
    tick(3);
    // Reset values
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(nibble_idx), 32'd0);
    check("rst_word", entry_word, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_seg", 32'(seg_nibble), 32'h7F);
    reset = 1'b0;
    tick(2);

    // Bouncing key: 2-cycle glitches never reach DEBOUNCE_CYCLES
    sw_nibble = 4'h3;
    for (int i = 0; i < 10; i++) begin
      key_next_n = 1'b0; tick(2);
      key_next_n = 1'b1; tick(2);
    end
    check("bounce_idx", 32'(nibble_idx), 32'd0);
    check("bounce_word", entry_word, 32'd0);
    press_next(4'h3);
    check_state("bounce_hold");
    check("bounce_idx_one", 32'(nibble_idx), 32'd1);

    // Eight digits fill the word and wrap the pointer; the ninth overwrites digit 0
    do_reset();
    check_state("after_reset");
    for (int i = 1; i <= 8; i++) press_next(4'(i));
    check_state("entry8");
    check("entry8_word", entry_word, 32'h87654321);
    press_next(4'hF);
    check("entry9_word", entry_word, 32'h8765432F);
    check_state("entry9");

    // Committed write acked three cycles after wr_en
    do_reset();
    foreach (seg_tab[i]) begin end
    press_next(4'hF); press_next(4'hE); press_next(4'hE); press_next(4'hB);
    press_next(4'hD); press_next(4'hA); press_next(4'hE); press_next(4'hD);
    check("deadbeef_word", entry_word, 32'hDEADBEEF);
    press_commit(5'd5, 3);
    check_state("commit_ok");

    // Register 0 is refused; next press clears err
    press_next(4'h6);
    press_commit(5'd0, 2);
    check("reg0_err", 32'(err), 32'd1);
    check_state("reg0");
    press_next(4'h7);
    check("reg0_err_clear", 32'(err), 32'd0);
    check_state("reg0_next");

    // Timeout with key presses during busy discarded
    ok = model_commit_start(5'd9, -1);
    sw_addr = 5'd9; ack_delay = -1; sw_nibble = 4'hC;
    key_commit_n = 1'b0;
    wait_busy();
    key_next_n = 1'b0;
    wait_idle();
    key_next_n = 1'b1; key_commit_n = 1'b1;
    tick(DB + 6);
    model_commit_end(5'd9, ok);
    check_state("timeout");

    // Simultaneous presses: commit wins and the nibble is not captured
    sw_addr = 5'd0; sw_nibble = 4'h9;
    key_next_n = 1'b0; key_commit_n = 1'b0;
    tick(DB + 6);
    key_next_n = 1'b1; key_commit_n = 1'b1;
    tick(DB + 6);
    m_err = 1'b1;
    check_state("simul");

    // Ack during the WRITE cycle is ignored and ends in timeout
    press_commit(5'd12, 0);
    check_state("ack_in_write");

    // Randomized operations against the model
    for (int it = 0; it < 40; it++) begin
      int op, d;
      logic [4:0] a;
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        press_next(4'($urandom_range(0, 15)));
      end else if (op == 2) begin
        a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d = $urandom_range(0, 10);
        if (d == 10) d = -1;
        press_commit(a, d);
      end else begin
        n = 4'($urandom_range(0, 15));
        sw_nibble = n;
        tick(2);
`ifdef LOADER_ECHO_SEG_EN
        check("rand_seg", 32'(seg_nibble), 32'(seg_tab[n]));
`else
        check("rand_seg", 32'(seg_nibble), 32'h7F);
`endif
      end
      check_state("rand");
    end

    // Asynchronous reset while waiting for ack
    press_next(4'h5);
    ok = model_commit_start(5'd3, -1);
    sw_addr = 5'd3; ack_delay = -1;
    key_commit_n = 1'b0;
    wait_busy();
    tick(3);
    check("pre_rst_wr_en", 32'(wr_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_wr_en", 32'(wr_en), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_word", entry_word, 32'd0);
    key_commit_n = 1'b1;
    tick(2);
    reset = 1'b0;
    model_clear();
    tick(DB + 6);
    check_state("after_async");

    // Segment echo one cycle after the switch changes
    sw_nibble = 4'hA;
    tick(2);
`ifdef LOADER_ECHO_SEG_EN
    check("seg_A", 32'(seg_nibble), 32'h08);
`else
    check("seg_A", 32'(seg_nibble), 32'h7F);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
